output_bank: RTL and testbench

Parametrised CPU output-device bank: NCH memory-mapped output registers, written by the processor through the device write port with byte enables and read back through a registered data port. A built-in scan sequencer walks the channels at a programmable rate and presents one channel per strobe, for multiplexed display drivers such as 7-segment or LED. Per-channel dirty flags record writes not yet scanned out. The bank sits on the CPU device bus alongside the other output peripherals.

---
 rtl/output_pkg.sv | 26 ++
 rtl/scan_divider.sv | 26 ++
 rtl/output_bank.sv | 107 ++++++++++
 tb/tb_output_bank.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/output_pkg.sv
// Shared helpers for the output device bank.
// Byte-lane merge and address-width derivation.
package output_pkg;

    localparam int MAX_DW = 512;
    localparam int MAX_BE = MAX_DW / 8;

    function automatic int aw_of(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Callers zero-extend into the wide form and truncate the result.
    function automatic logic [MAX_DW-1:0] merge(
        input logic [MAX_DW-1:0] old,
        input logic [MAX_DW-1:0] din,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_DW-1:0] r;
        r = old;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) r[i*8 +: 8] = din[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_divider.sv
// Free-running modulo-SCAN_DIV counter.
// tick is high during the terminal-count cycle.
module scan_divider #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/output_bank.sv
// Memory-mapped output channel bank with byte-enable writes,
// registered readback, scan sequencer and per-channel dirty flags.
module output_bank
    import output_pkg::*;
#(
    parameter int            DW       = 32,
    parameter int            NCH      = 4,
    parameter int            SCAN_DIV = 50000,
    parameter logic [DW-1:0] RST_VAL  = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_dev,
    input  logic [aw_of(NCH)-1:0]   dev_addr,
    input  logic [DW/8-1:0]         be,
    input  logic [DW-1:0]           din,
    output logic [DW-1:0]           dout,
    output logic [DW-1:0]           scan_val,
    output logic [aw_of(NCH)-1:0]   scan_idx,
    output logic                    scan_strobe,
    output logic [NCH-1:0]          dirty
);

    localparam int AW = aw_of(NCH);

    logic [DW-1:0]  chan_q [NCH];
    logic [DW-1:0]  chan_d [NCH];
    logic [DW-1:0]  dout_q, dout_d;
    logic [DW-1:0]  scan_val_q, scan_val_d;
    logic [AW-1:0]  scan_idx_q, scan_idx_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic           scan_strobe_q, scan_strobe_d;
    logic [NCH-1:0] dirty_q, dirty_d;
    logic           scan_tick;

    scan_divider #(
        .SCAN_DIV(SCAN_DIV)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .tick(scan_tick)
    );

    always_comb begin
        chan_d        = chan_q;
        dirty_d       = dirty_q;
        dout_d        = '0;
        scan_val_d    = scan_val_q;
        scan_idx_d    = scan_idx_q;
        scan_strobe_d = scan_tick;
        ptr_d         = ptr_q;

        for (int i = 0; i < NCH; i++) begin
            if (we_dev && dev_addr == AW'(i))
                chan_d[i] = DW'(merge(MAX_DW'(chan_q[i]), MAX_DW'(din),
                                      MAX_BE'(be)));
        end

        // Unmatched addresses (NCH not a power of 2) read back as zero.
        for (int i = 0; i < NCH; i++) begin
            if (dev_addr == AW'(i)) dout_d = chan_d[i];
        end

        if (scan_tick) begin
            scan_idx_d = ptr_q;
            ptr_d      = (ptr_q == AW'(NCH - 1)) ? '0 : ptr_q + AW'(1);
            for (int i = 0; i < NCH; i++) begin
                if (ptr_q == AW'(i)) begin
                    scan_val_d = chan_d[i];
                    dirty_d[i] = 1'b0;
                end
            end
        end

        // Applied after the scan clear so a colliding write keeps dirty set.
        for (int i = 0; i < NCH; i++) begin
            if (we_dev && dev_addr == AW'(i)) dirty_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) chan_q[i] <= RST_VAL;
            dout_q        <= '0;
            scan_val_q    <= '0;
            scan_idx_q    <= '0;
            scan_strobe_q <= 1'b0;
            dirty_q       <= '0;
            ptr_q         <= '0;
        end else begin
            chan_q        <= chan_d;
            dout_q        <= dout_d;
            scan_val_q    <= scan_val_d;
            scan_idx_q    <= scan_idx_d;
            scan_strobe_q <= scan_strobe_d;
            dirty_q       <= dirty_d;
            ptr_q         <= ptr_d;
        end
    end

    assign dout        = dout_q;
    assign scan_val    = scan_val_q;
    assign scan_idx    = scan_idx_q;
    assign scan_strobe = scan_strobe_q;
    assign dirty       = dirty_q;

endmodule

// File: tb/tb_output_bank.sv
// Directed bench for output_bank: one 4-channel instance and
// one 3-channel instance sharing clock and reset.
module tb_output_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        we_a = 1'b0;
    logic [1:0]  addr_a = '0;
    logic [3:0]  be_a = '0;
    logic [31:0] din_a = '0;
    logic [31:0] dout_a, sval_a;
    logic [1:0]  sidx_a;
    logic        sstb_a;
    logic [3:0]  dirty_a;

    logic        we_b = 1'b0;
    logic [1:0]  addr_b = '0;
    logic [3:0]  be_b = '0;
    logic [31:0] din_b = '0;
    logic [31:0] dout_b, sval_b;
    logic [1:0]  sidx_b;
    logic        sstb_b;
    logic [2:0]  dirty_b;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] vals [4];
    logic [31:0] last_val;

    always #5 clk = ~clk;

    output_bank #(
        .DW(32), .NCH(4), .SCAN_DIV(4), .RST_VAL(32'hA5A5A5A5)
    ) dut_a (
        .clk(clk), .rst(rst), .we_dev(we_a), .dev_addr(addr_a),
        .be(be_a), .din(din_a), .dout(dout_a), .scan_val(sval_a),
        .scan_idx(sidx_a), .scan_strobe(sstb_a), .dirty(dirty_a)
    );

    output_bank #(
        .DW(32), .NCH(3), .SCAN_DIV(2), .RST_VAL(32'h0)
    ) dut_b (
        .clk(clk), .rst(rst), .we_dev(we_b), .dev_addr(addr_b),
        .be(be_b), .din(din_b), .dout(dout_b), .scan_val(sval_b),
        .scan_idx(sidx_b), .scan_strobe(sstb_b), .dirty(dirty_b)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vals[0] = 32'h10; vals[1] = 32'h20;
        vals[2] = 32'h30; vals[3] = 32'h40;

        // reset held with write activity
        we_a = 1'b1; addr_a = 2'd0; din_a = 32'h0; be_a = 4'hF;
        tick(); we_a = 1'b0;
        tick(); we_a = 1'b1;
        tick();
        check("rst_dout", dout_a, 32'h0);
        check("rst_dirty", 32'(dirty_a), 32'h0);
        check("rst_strobe", 32'(sstb_a), 32'h0);
        check("rst_sval", sval_a, 32'h0);
        check("rst_sidx", 32'(sidx_a), 32'h0);
        we_a = 1'b0; addr_a = 2'd0; rst = 1'b1;
        tick();
        check("rstval_ch0", dout_a, 32'hA5A5A5A5);
        addr_a = 2'd3;
        tick();
        check("rstval_ch3", dout_a, 32'hA5A5A5A5);
        check("no_strobe_e2", 32'(sstb_a), 32'h0);
        tick();
        check("no_strobe_e3", 32'(sstb_a), 32'h0);
        tick();
        check("first_strobe", 32'(sstb_a), 32'h1);
        check("first_idx", 32'(sidx_a), 32'h0);
        check("first_val", sval_a, 32'hA5A5A5A5);
        tick();
        check("strobe_one_cycle", 32'(sstb_a), 32'h0);

        // byte-enable writes
        do_reset();
        we_a = 1'b1; addr_a = 2'd2; din_a = 32'h11223344; be_a = 4'hF;
        tick();
        check("wr_full", dout_a, 32'h11223344);
        din_a = 32'hFFFFFFFF; be_a = 4'b0101;
        tick();
        check("wr_be0101", dout_a, 32'h11FF33FF);
        check("dirty_ch2", 32'(dirty_a), 32'h4);
        we_a = 1'b0;
        tick();
        check("readback_hold", dout_a, 32'h11FF33FF);
        tick();
        check("dirty_after_scan0", 32'(dirty_a), 32'h4);
        we_a = 1'b1; addr_a = 2'd3; din_a = 32'h12345678; be_a = 4'h0;
        tick();
        check("dirty_be0", 32'(dirty_a), 32'hC);
        check("be0_no_change", dout_a, 32'hA5A5A5A5);
        we_a = 1'b0;

        // scan order
        do_reset();
        we_a = 1'b1; be_a = 4'hF;
        addr_a = 2'd0; din_a = 32'h10; tick();
        addr_a = 2'd1; din_a = 32'h20; tick();
        addr_a = 2'd2; din_a = 32'h30; tick();
        addr_a = 2'd3; din_a = 32'h40; tick();
        we_a = 1'b0;
        check("scan_e4_stb", 32'(sstb_a), 32'h1);
        check("scan_e4_idx", 32'(sidx_a), 32'h0);
        check("scan_e4_val", sval_a, 32'h10);
        check("scan_e4_dirty", 32'(dirty_a), 32'hE);
        last_val = 32'h10;
        for (int e = 5; e <= 20; e++) begin
            tick();
            if (e % 4 == 0) begin
                check("scan_stb", 32'(sstb_a), 32'h1);
                check("scan_idx", 32'(sidx_a), 32'((e / 4 - 1) % 4));
                check("scan_val", sval_a, vals[(e / 4 - 1) % 4]);
                last_val = vals[(e / 4 - 1) % 4];
            end else begin
                check("scan_gap_stb", 32'(sstb_a), 32'h0);
                check("scan_gap_hold", sval_a, last_val);
            end
            if (e == 16) check("dirty_all_clear", 32'(dirty_a), 32'h0);
        end

        // write colliding with scan of the same channel
        tick(); tick(); tick();
        we_a = 1'b1; addr_a = 2'd1; din_a = 32'h55; be_a = 4'hF;
        tick();
        we_a = 1'b0;
        check("coll_stb", 32'(sstb_a), 32'h1);
        check("coll_idx", 32'(sidx_a), 32'h1);
        check("coll_val", sval_a, 32'h55);
        check("coll_dirty", 32'(dirty_a), 32'h2);
        tick(); tick(); tick(); tick();
        check("post_coll_idx", 32'(sidx_a), 32'h2);
        check("post_coll_val", sval_a, 32'h30);
        check("post_coll_dirty", 32'(dirty_a), 32'h2);

        // reset in the middle of a scan interval
        tick(); tick();
        rst = 1'b0;
        #1;
        check("midrst_sidx", 32'(sidx_a), 32'h0);
        check("midrst_sval", sval_a, 32'h0);
        check("midrst_dirty", 32'(dirty_a), 32'h0);
        check("midrst_dout", dout_a, 32'h0);
        tick();
        rst = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("midrst_no_stb", 32'(sstb_a), 32'h0);
        end
        tick();
        check("midrst_stb", 32'(sstb_a), 32'h1);
        check("midrst_idx", 32'(sidx_a), 32'h0);
        check("midrst_val", sval_a, 32'hA5A5A5A5);

        // three-channel instance: out of range and wrap
        do_reset();
        we_b = 1'b1; addr_b = 2'd1; din_b = 32'h77; be_b = 4'hF;
        tick();
        check("b_wr", dout_b, 32'h77);
        check("b_dirty", 32'(dirty_b), 32'h2);
        addr_b = 2'd3; din_b = 32'hFFFFFFFF;
        tick();
        check("b_oor_dout", dout_b, 32'h0);
        check("b_oor_dirty", 32'(dirty_b), 32'h2);
        check("b_stb0", 32'(sstb_b), 32'h1);
        check("b_idx0", 32'(sidx_b), 32'h0);
        check("b_val0", sval_b, 32'h0);
        we_b = 1'b0; addr_b = 2'd1;
        tick();
        check("b_ch1_kept", dout_b, 32'h77);
        check("b_gap", 32'(sstb_b), 32'h0);
        addr_b = 2'd0;
        tick();
        check("b_idx1", 32'(sidx_b), 32'h1);
        check("b_val1", sval_b, 32'h77);
        check("b_dirty_clr", 32'(dirty_b), 32'h0);
        check("b_ch0_zero", dout_b, 32'h0);
        addr_b = 2'd2;
        tick();
        check("b_ch2_zero", dout_b, 32'h0);
        tick();
        check("b_idx2", 32'(sidx_b), 32'h2);
        tick(); tick();
        check("b_wrap_stb", 32'(sstb_b), 32'h1);
        check("b_wrap_idx", 32'(sidx_b), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
